// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM arbiter block.
package sram_arb_pkg;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Channel-index width; never below one bit so single-bit ports stay legal.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: per-channel request lanes plus the
// shared response. The arbiter takes the slave side, requesters the master side.
interface sram_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();
  localparam int BW = DATA_W / 8;
  localparam int CW = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0]             req_valid;
  logic [NUM_CH-1:0]             req_ready;
  logic [NUM_CH-1:0][BW-1:0]     req_we;
  logic [NUM_CH-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] req_wdata;
  logic                          rsp_valid;
  logic [CW-1:0]                 rsp_ch;
  logic [DATA_W-1:0]             rsp_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_ch, rsp_rdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_ch, rsp_rdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requesting channel at or after the pointer,
// wrapping from the top channel back to 0.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int CW = ch_idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [CW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [CW-1:0] o_grant_idx,
  output logic          o_any
);
  logic [CW-1:0] w_cand;

  // Scan farthest offset first so the nearest requester is the last writer.
  always_comb begin
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_cand      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = CW'((int'(i_ptr) + k) % N);
      if (i_req[w_cand]) begin
        o_grant_idx = w_cand;
        o_any       = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign o_grant[gi] = o_any && (o_grant_idx == CW'(gi));
  end
endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM among NUM_CH requesters. Each transfer takes two
// cycles: issue (address/write strobe) then data phase; response one cycle later.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int NUM_CH = 2,
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int BW     = DATA_W / 8,
  localparam int CW     = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  sram_arbiter_if.slave     bus,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic [BW-1:0]     sram_web,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
);
  state_t            r_state;
  state_t            w_next_state;
  logic [CW-1:0]     r_ptr;
  logic [CW-1:0]     r_ch;
  logic [ADDR_W-1:0] r_addr;
  logic              r_is_read;
  logic              r_rsp_valid;
  logic [CW-1:0]     r_rsp_ch;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_grant;
  logic [CW-1:0]     w_gidx;
  logic              w_any;

  // Requests only compete while idle and out of reset.
  assign w_req = (r_state == IDLE && !rst) ? bus.req_valid : '0;

  rr_arbiter #(.N(NUM_CH)) u_rr (
    .i_req       (w_req),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx),
    .o_any       (w_any)
  );

  always_comb begin
    w_next_state  = r_state;
    bus.req_ready = '0;
    sram_cs       = 1'b0;
    sram_oe       = 1'b0;
    sram_web      = '1;
    sram_addr     = r_addr;
    sram_di       = '0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            bus.req_ready = w_grant;
            sram_cs       = 1'b1;
            sram_web      = ~bus.req_we[w_gidx];
            sram_addr     = bus.req_addr[w_gidx];
            sram_di       = bus.req_wdata[w_gidx];
            w_next_state  = BUSY;
          end
        end
        BUSY: begin
          sram_cs      = 1'b1;
          sram_oe      = r_is_read;
          w_next_state = IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_ch    = r_rsp_ch;
  assign bus.rsp_rdata = r_rsp_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_ch        <= '0;
      r_addr      <= '0;
      r_is_read   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_ch    <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_next_state;
      r_rsp_valid <= 1'b0;
      if (r_state == IDLE && w_any) begin
        r_ptr     <= (w_gidx == CW'(NUM_CH - 1)) ? '0 : w_gidx + 1'b1;
        r_ch      <= w_gidx;
        r_addr    <= bus.req_addr[w_gidx];
        r_is_read <= (bus.req_we[w_gidx] == '0);
      end
      // Data phase ends here: the SRAM output is valid for reads.
      if (r_state == BUSY) begin
        r_rsp_valid <= 1'b1;
        r_rsp_ch    <= r_ch;
        r_rsp_rdata <= r_is_read ? sram_do : '0;
      end
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter with four channels: directed scenarios plus random
// traffic checked against a transaction-level model of arbitration and memory.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int NCH   = 4;
  localparam int AW    = DEF_ADDR_W;
  localparam int DW    = DEF_DATA_W;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          sram_cs, sram_oe;
  logic [BW-1:0] sram_web;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_di, sram_do;

  sram_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
    .sram_addr(sram_addr), .sram_di(sram_di), .sram_do(sram_do)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM stand-in: byte-lane writes, registered read when no lane writes.
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (sram_cs) begin
      for (int b = 0; b < BW; b++)
        if (!sram_web[b]) sram_mem[sram_addr][8*b +: 8] <= sram_di[8*b +: 8];
      if (&sram_web) sram_do <= sram_mem[sram_addr];
    end
  end

  always @(negedge clk)
    if (bus.rsp_valid === 1'b1)
      $display("rsp: ch=%0d rdata=%08h t=%0t", bus.rsp_ch, bus.rsp_rdata, $time);

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory contents, pointer, in-flight transfer, response.
  logic [DW-1:0] ref_mem [DEPTH];
  int            m_ptr = 0;
  bit            m_busy = 0;
  bit            m_pend_read = 0;
  int            m_pend_ch = 0;
  logic [AW-1:0] m_pend_addr = '0;
  bit            m_rsp_valid = 0;
  int            m_rsp_ch = 0;
  logic [DW-1:0] m_rsp_data = '0;
  int            exp_win;
  logic [NCH-1:0] exp_ready;
  bit            exp_cs, exp_oe;
  logic [BW-1:0] exp_web;
  logic [AW-1:0] exp_addr;

  function automatic void model_eval();
    exp_win = -1;
    if (!rst && !m_busy)
      for (int k = 0; k < NCH; k++)
        if (exp_win < 0 && bus.req_valid[(m_ptr + k) % NCH]) exp_win = (m_ptr + k) % NCH;
    exp_ready = '0;
    if (exp_win >= 0) exp_ready[exp_win] = 1'b1;
    exp_cs   = !rst && (m_busy || exp_win >= 0);
    exp_oe   = !rst && m_busy && m_pend_read;
    exp_web  = (exp_win >= 0) ? ~bus.req_we[exp_win] : '1;
    exp_addr = m_busy ? m_pend_addr : ((exp_win >= 0) ? bus.req_addr[exp_win] : '0);
  endfunction

  function automatic void model_commit();
    logic [BW-1:0] we;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_rsp_valid = 0; m_rsp_ch = 0; m_rsp_data = '0;
      return;
    end
    m_rsp_valid = 0;
    if (m_busy) begin
      m_busy      = 0;
      m_rsp_valid = 1;
      m_rsp_ch    = m_pend_ch;
      m_rsp_data  = m_pend_read ? ref_mem[m_pend_addr] : '0;
    end else if (exp_win >= 0) begin
      we = bus.req_we[exp_win];
      for (int b = 0; b < BW; b++)
        if (we[b]) ref_mem[bus.req_addr[exp_win]][8*b +: 8] = bus.req_wdata[exp_win][8*b +: 8];
      m_busy      = 1;
      m_pend_read = (we == '0);
      m_pend_ch   = exp_win;
      m_pend_addr = bus.req_addr[exp_win];
      m_ptr       = (exp_win + 1) % NCH;
    end
  endfunction

  task automatic settle(); @(negedge clk); model_eval(); endtask
  task automatic tick(); model_commit(); @(posedge clk); #1; endtask
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin settle(); tick(); end
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
  endtask

  task automatic set_req(input int ch, input logic [BW-1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[ch] = 1'b1; bus.req_we[ch] = we; bus.req_addr[ch] = a; bus.req_wdata[ch] = d;
  endtask

  // One lone-channel transfer; returns the response seen exactly two cycles after the grant.
  task automatic do_xfer(input int ch, input logic [BW-1:0] we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output logic [DW-1:0] rd, output bit got);
    bit granted = 0;
    got = 0; rd = '0;
    clear_reqs(); set_req(ch, we, a, d);
    for (int i = 0; i < 8; i++) begin
      settle(); granted = bus.req_ready[ch]; tick();
      if (granted) break;
    end
    clear_reqs();
    if (granted) begin
      settle(); tick();
      settle(); got = (bus.rsp_valid === 1'b1) && (bus.rsp_ch === 2'(ch)); rd = bus.rsp_rdata; tick();
    end
  endtask

  task automatic pulse_reset();
    rst = 1; clear_reqs(); settle(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = NCH'($urandom); bus.req_we = '1; bus.req_addr = '0; bus.req_wdata = '0;
      settle();
      n_checks++;
      if (bus.req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
      n_checks++;
      if (sram_cs !== 1'b0 || sram_web !== '1) begin
        n_fail++; $display("FAIL reset_sram: cs=%b web=%h want cs=0 web=f", sram_cs, sram_web);
      end
      tick();
    end
    rst = 0; clear_reqs();
    settle();
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_ch !== '0 || bus.rsp_rdata !== '0) begin
      n_fail++; $display("FAIL reset_rsp: valid=%b ch=%0d rdata=%h want 0/0/0", bus.rsp_valid, bus.rsp_ch, bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] want [2];
    want[0] = '0; want[1] = 32'hDEADBEEF;
    for (int t = 0; t < 2; t++) begin
      clear_reqs(); set_req(0, (t == 0) ? 4'hF : 4'h0, 14'h0010, 32'hDEADBEEF);
      settle();
      n_checks++;
      if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL wr_rd_grant[%0d]: got %b want 0001", t, bus.req_ready); end
      tick(); clear_reqs();
      settle();
      n_checks++;
      if (bus.rsp_valid !== 1'b0 || sram_cs !== 1'b1 || sram_oe !== (t == 1)) begin
        n_fail++; $display("FAIL wr_rd_busy[%0d]: rsp_valid=%b cs=%b oe=%b want 0/1/%0d", t, bus.rsp_valid, sram_cs, sram_oe, t);
      end
      tick();
      settle();
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_ch !== 2'd0 || bus.rsp_rdata !== want[t]) begin
        n_fail++; $display("FAIL wr_rd_rsp[%0d]: valid=%b ch=%0d rdata=%h want 1/0/%h", t, bus.rsp_valid, bus.rsp_ch, bus.rsp_rdata, want[t]);
      end
      tick();
    end
  endtask

  task automatic test_partial_write();
    logic [DW-1:0] rd;
    bit got;
    do_xfer(1, 4'hF, 14'h0020, 32'h11223344, rd, got);
    n_checks++;
    if (!got || rd !== '0) begin n_fail++; $display("FAIL part_full_wr: got=%0d rdata=%h want 1/0", got, rd); end
    do_xfer(1, 4'b0011, 14'h0020, 32'hAAAABBBB, rd, got);
    n_checks++;
    if (!got || rd !== '0) begin n_fail++; $display("FAIL part_lane_wr: got=%0d rdata=%h want 1/0", got, rd); end
    do_xfer(1, 4'h0, 14'h0020, 32'h0, rd, got);
    n_checks++;
    if (!got || rd !== 32'h1122BBBB) begin n_fail++; $display("FAIL part_readback: got=%0d rdata=%h want 1/1122bbbb", got, rd); end
  endtask

  task automatic test_alternate();
    int gch[$];
    int gcyc[$];
    pulse_reset();
    for (int c = 0; c < 16; c++) begin
      clear_reqs(); set_req(0, '0, 14'h0010, '0); set_req(1, '0, 14'h0020, '0);
      settle();
      n_checks++;
      if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL alt_ready cyc=%0d: got %b want %b", c, bus.req_ready, exp_ready); end
      for (int b = 0; b < NCH; b++)
        if (bus.req_ready[b]) begin gch.push_back(b); gcyc.push_back(c); end
      tick();
    end
    clear_reqs(); idle_cycles(2);
    n_checks++;
    if (gch.size() != 8) begin n_fail++; $display("FAIL alt_count: got %0d grants want 8", gch.size()); end
    for (int i = 0; i < gch.size() && i < 8; i++) begin
      n_checks++;
      if (gch[i] != i % 2 || gcyc[i] != 2 * i) begin
        n_fail++; $display("FAIL alt_seq[%0d]: ch=%0d cyc=%0d want ch=%0d cyc=%0d", i, gch[i], gcyc[i], i % 2, 2 * i);
      end
    end
  endtask

  task automatic test_lone_ch3();
    logic [DW-1:0] rd;
    bit got;
    pulse_reset();
    do_xfer(0, '0, 14'h0005, '0, rd, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL lone_setup: got 0 want 1"); end
    clear_reqs(); set_req(3, '0, 14'h0007, '0);
    settle();
    n_checks++;
    if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL lone_ch3_grant: got %b want 1000", bus.req_ready); end
    tick(); clear_reqs(); idle_cycles(2);
    for (int ch = 0; ch < NCH; ch++) set_req(ch, '0, 14'h0001, '0);
    settle();
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL lone_ptr_wrap: got %b want 0001", bus.req_ready); end
    tick(); clear_reqs(); idle_cycles(2);
  endtask

  task automatic test_reset_busy();
    clear_reqs(); set_req(2, '0, 14'h0020, '0);
    settle();
    n_checks++;
    if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL rstbusy_grant: got %b want 0100", bus.req_ready); end
    tick(); clear_reqs();
    rst = 1;
    settle();
    n_checks++;
    if (sram_cs !== 1'b0 || bus.req_ready !== '0) begin n_fail++; $display("FAIL rstbusy_cs: cs=%b ready=%b want 0/0000", sram_cs, bus.req_ready); end
    tick(); rst = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstbusy_no_rsp[%0d]: got %b want 0", i, bus.rsp_valid); end
      tick();
    end
    for (int ch = 0; ch < NCH; ch++) set_req(ch, '0, 14'h0003, '0);
    settle();
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstbusy_next: got %b want 0001", bus.req_ready); end
    tick(); clear_reqs(); idle_cycles(2);
  endtask

  task automatic test_idle();
    clear_reqs(); idle_cycles(3);
    for (int i = 0; i < 10; i++) begin
      settle();
      n_checks++;
      if (sram_cs !== 1'b0 || bus.req_ready !== '0 || bus.rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL idle[%0d]: cs=%b ready=%b rsp_valid=%b want 0", i, sram_cs, bus.req_ready, bus.rsp_valid);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int ch = 0; ch < NCH; ch++) begin
        bus.req_valid[ch] = ($urandom_range(0, 2) != 0);
        bus.req_we[ch]    = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom);
        bus.req_addr[ch]  = AW'($urandom_range(0, 31));
        bus.req_wdata[ch] = $urandom;
      end
      settle();
      n_checks++;
      if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready cyc=%0d: got %b want %b", c, bus.req_ready, exp_ready); end
      n_checks++;
      if (sram_cs !== exp_cs || sram_oe !== exp_oe || sram_web !== exp_web) begin
        n_fail++; $display("FAIL rnd_ctrl cyc=%0d: cs/oe/web=%b/%b/%h want %b/%b/%h", c, sram_cs, sram_oe, sram_web, exp_cs, exp_oe, exp_web);
      end
      if (exp_cs) begin
        n_checks++;
        if (sram_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr cyc=%0d: got %h want %h", c, sram_addr, exp_addr); end
      end
      if (exp_win >= 0) begin
        n_checks++;
        if (sram_di !== bus.req_wdata[exp_win]) begin n_fail++; $display("FAIL rnd_di cyc=%0d: got %h want %h", c, sram_di, bus.req_wdata[exp_win]); end
      end
      n_checks++;
      if (bus.rsp_valid !== m_rsp_valid) begin n_fail++; $display("FAIL rnd_rsp_valid cyc=%0d: got %b want %b", c, bus.rsp_valid, m_rsp_valid); end
      if (m_rsp_valid) begin
        n_checks++;
        if (bus.rsp_ch !== 2'(m_rsp_ch) || bus.rsp_rdata !== m_rsp_data) begin
          n_fail++; $display("FAIL rnd_rsp cyc=%0d: ch=%0d rdata=%h want ch=%0d rdata=%h", c, bus.rsp_ch, bus.rsp_rdata, m_rsp_ch, m_rsp_data);
        end
      end
      tick();
    end
    rst = 0; clear_reqs(); idle_cycles(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_reqs();
    for (int i = 0; i < DEPTH; i++) begin sram_mem[i] = '0; ref_mem[i] = '0; end
    test_reset();
    test_write_read();
    test_partial_write();
    test_alternate();
    test_lone_ch3();
    test_reset_busy();
    test_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requester channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 14, SRAM word-address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; byte-lane count BW = DATA_W/8.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_CH  per-channel request valid.
REQ-007 SHALL have port req_ready  output  NUM_CH  per-channel accept; at most one bit high per cycle.
REQ-008 SHALL have port req_we  input  NUM_CH x BW  byte write enables; all-zero = read.
REQ-009 SHALL have port req_addr  input  NUM_CH x ADDR_W  word address.
REQ-010 SHALL have port req_wdata  input  NUM_CH x DATA_W  write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-012 SHALL have port rsp_ch  output  $clog2(NUM_CH)  channel owning the response.
REQ-013 SHALL have port rsp_rdata  output  DATA_W  read data (zero for writes).
REQ-014 SHALL have ports sram_cs/sram_oe (output 1), sram_web (output BW, active-low), sram_addr (output ADDR_W), sram_di (output DATA_W), sram_do (input DATA_W) to one SRAM_wrapper.

Function
REQ-015 SHALL implement FSM states IDLE and BUSY.
REQ-016 In IDLE, SHALL select one winner among asserted req_valid by round-robin and raise only its req_ready combinationally; transfer occurs when valid&&ready.
REQ-017 On transfer (cycle N), SHALL drive sram_cs=1, sram_addr/sram_di from winner, sram_web=~req_we, sram_oe=0, and move to BUSY.
REQ-018 In BUSY (cycle N+1), SHALL hold req_ready all-zero, drive sram_cs=1, sram_oe=1 for reads (0 for writes), sram_web=all-ones, sram_addr held; return to IDLE.
REQ-019 At end of BUSY, SHALL register sram_do (reads) or zero (writes) into rsp_rdata; rsp_valid=1 and rsp_ch=winner during cycle N+2 only.
REQ-020 Latency SHALL be 2 cycles issue-to-rsp_valid; throughput one transfer per 2 cycles; a new grant may coincide with rsp_valid.
REQ-021 Round-robin pointer SHALL reset to channel 0; after each transfer by channel k, pointer = (k+1) mod NUM_CH; without a transfer the pointer SHALL hold.
REQ-022 Search SHALL start at pointer and wrap NUM_CH-1 -> 0; a lone requester SHALL win every IDLE cycle regardless of pointer.
REQ-023 No req_valid in IDLE: SHALL drive sram_cs=0, sram_oe=0, sram_web=all-ones, stay IDLE.
REQ-024 Partial req_we (e.g. 4'b0011) SHALL write only enabled lanes; rsp_rdata=0.
REQ-025 req_valid deasserted by a requester before ready SHALL be allowed; no state kept for ungranted requests.

Reset
REQ-026 With rst=1 at a rising edge, SHALL enter IDLE, pointer=0, rsp_valid=0, rsp_ch=0, rsp_rdata=0, next cycle.
REQ-027 While rst=1, req_ready SHALL be all-zero and sram_cs=0, sram_web=all-ones.
REQ-028 Reset during BUSY SHALL abort; the pending response SHALL never be issued.

Structure
REQ-029 Shared package sram_arb_pkg SHALL hold the state enum (IDLE, BUSY) and default widths (ADDR_W=14, DATA_W=32).
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, pointer; outputs one-hot grant, grant index).
REQ-031 RTL SHALL be synthesizable, no latches, one always_ff block for state/pointer/response.

Verification
REQ-032 Ch0 write addr 0x0010 data 0xDEADBEEF we 4'hF, then ch0 read 0x0010 -> rsp_valid 2 cycles after each transfer, read rsp_rdata=0xDEADBEEF, rsp_ch=0.
REQ-033 Ch0 and ch1 both valid continuously from reset, reads -> grants alternate 0,1,0,1 every 2 cycles.
REQ-034 Prior word 0x11223344, write we=4'b0011 data 0xAAAABBBB, read back -> 0x1122BBBB.
REQ-035 rst pulse in BUSY of a read -> no rsp_valid, next grant goes to channel 0.
REQ-036 NUM_CH=4, only ch3 valid while pointer=1 -> ch3 granted, pointer becomes 0.
REQ-037 No requests for 10 cycles -> sram_cs=0, req_ready=0, rsp_valid=0 throughout.
